// File: rtl/dot_seq_pkg.sv
// Shared types and widths for the dot-product sequencer.
// Imported by the interface and the dot_prod_seq top.
package dot_seq_pkg;

    localparam int OP_W      = 16;
    localparam int ACC_W     = 64;
    localparam int PROD_W    = 32;
    localparam int DRAIN_CYC = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        DRAIN1,
        DRAIN2,
        DONE
    } state_t;

endpackage

// File: rtl/dot_prod_seq_if.sv
// Operand stream and result handshakes of the dot-product sequencer.
// The master modport is the operand source and result consumer side.
interface dot_prod_seq_if;
    import dot_seq_pkg::*;

    logic            op_vld;
    logic            op_rdy;
    logic [OP_W-1:0] op_a;
    logic [OP_W-1:0] op_b;

    logic [ACC_W-1:0] res;
    logic             res_vld;
    logic             res_rdy;

    modport master (
        output op_vld, op_a, op_b, res_rdy,
        input  op_rdy, res, res_vld
    );

    modport slave (
        input  op_vld, op_a, op_b, res_rdy,
        output op_rdy, res, res_vld
    );

endinterface

// File: rtl/dot_prod_seq.sv
// Dot-product sequencer driving an external two-stage gated-clock MAC.
// Optional abort input is built only when DOT_SEQ_ABORT_EN is defined.
module dot_prod_seq
    import dot_seq_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    dot_prod_seq_if.slave    bus,
    output logic             mac_clr,
    output logic             mac_en,
    output logic [OP_W-1:0]  mac_a,
    output logic [OP_W-1:0]  mac_b,
    input  logic [ACC_W-1:0] mac_accum,
    output logic             busy
`ifdef DOT_SEQ_ABORT_EN
    ,
    input  logic             abort
`endif
);

    state_t           state;
    state_t           nxt;
    logic [LEN_W-1:0] cnt;
    logic [ACC_W-1:0] res_q;
    logic             kill;
    logic             xfer;

`ifdef DOT_SEQ_ABORT_EN
    assign kill = abort && (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    assign xfer = (state == RUN) && bus.op_vld && !kill;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = CLR;
            CLR:     nxt = (cnt != '0) ? RUN : DRAIN1;
            RUN:     if (xfer && cnt == LEN_W'(1)) nxt = DRAIN1;
            DRAIN1:  nxt = DRAIN2;
            DRAIN2:  nxt = DONE;
            DONE:    if (bus.res_rdy) nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (kill) nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            res_q <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && start)
                cnt <= len;
            else if (xfer)
                cnt <= cnt - 1'b1;
            // accum reflects the last product two edges after its en
            if (state == DRAIN2 && !kill)
                res_q <= mac_accum;
        end
    end

    assign mac_a       = bus.op_a;
    assign mac_b       = bus.op_b;
    assign mac_en      = xfer;
    assign mac_clr     = (state == CLR);
    assign bus.op_rdy  = (state == RUN) && !kill;
    assign bus.res     = res_q;
    assign bus.res_vld = (state == DONE);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_dot_prod_seq.sv
// Directed bench for dot_prod_seq with a behavioural two-stage MAC.
module tb_dot_prod_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        mac_clr;
    logic        mac_en;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic [63:0] mac_accum;
    logic        busy;
`ifdef DOT_SEQ_ABORT_EN
    logic        abort;
`endif

    dot_prod_seq_if bus ();

    dot_prod_seq #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .bus       (bus.slave),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_accum (mac_accum),
        .busy      (busy)
`ifdef DOT_SEQ_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    // MAC: product at edge t, accumulate at edge t+1
    logic [31:0] prod = '0;
    logic        pv   = 1'b0;
    logic [63:0] acc  = '0;
    always @(posedge clk) begin
        prod <= mac_a * mac_b;
        pv   <= mac_en && !mac_clr;
        if (mac_clr)
            acc <= '0;
        else if (pv)
            acc <= acc + {32'h0, prod};
    end
    assign mac_accum = acc;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] va [8];
    logic [15:0] vb [8];

    int          o_vld_cyc;
    int          o_en_cnt;
    int          o_clr_cnt;
    int          o_clr_cyc;
    int          o_ovl;
    int          o_pass_err;
    logic        o_idle0;
    logic [63:0] o_res;

    task automatic run_vec(input int n, input bit gap, input bit rdy);
        int  cyc;
        int  idx;
        bit  done;
        o_vld_cyc  = -1;
        o_en_cnt   = 0;
        o_clr_cnt  = 0;
        o_clr_cyc  = -1;
        o_ovl      = 0;
        o_pass_err = 0;
        done       = 0;
        idx        = 0;
        @(negedge clk);
        start = 1'b1;
        len = n[7:0];
        bus.op_vld = 1'b0;
        bus.res_rdy = rdy;
        #1;
        o_idle0 = !busy;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        for (int k = 0; k < 200 && !done; k++) begin
            bus.op_vld = gap ? (cyc % 2 == 0) : 1'b1;
            bus.op_a = va[idx];
            bus.op_b = vb[idx];
            #1;
            if (mac_clr) begin
                o_clr_cnt++;
                o_clr_cyc = cyc;
            end
            if (mac_clr && mac_en) o_ovl++;
            if (mac_a !== bus.op_a || mac_b !== bus.op_b)
                o_pass_err++;
            if (mac_en) begin
                o_en_cnt++;
                if (idx < 7) idx++;
            end
            if (bus.res_vld) begin
                o_vld_cyc = cyc;
                o_res = bus.res;
                done = 1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.op_vld = 1'b0;
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL timeout res_vld never seen len=%0d", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        bus.op_vld = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.res_rdy = 1'b0;
`ifdef DOT_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({busy, bus.res_vld, bus.op_rdy, mac_en, mac_clr} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctl got %b want 00000",
                {busy, bus.res_vld, bus.op_rdy, mac_en, mac_clr});
        end
        vectors++;
        if (bus.res !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_res got %0h want 0", bus.res);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        va[0] = 1; vb[0] = 2;
        va[1] = 3; vb[1] = 4;
        va[2] = 5; vb[2] = 6;
        va[3] = 7; vb[3] = 8;
        run_vec(4, 0, 1);
        vectors++;
        if (o_res !== 64'd100) begin
            miscompares++;
            $display("FAIL basic_res got %0d want 100", o_res);
        end
        vectors++;
        if (o_vld_cyc !== 8) begin
            miscompares++;
            $display("FAIL basic_vld_cyc got %0d want 8", o_vld_cyc);
        end
        vectors++;
        if (o_clr_cnt !== 1 || o_clr_cyc !== 1) begin
            miscompares++;
            $display("FAIL basic_clr got n=%0d c=%0d want n=1 c=1",
                o_clr_cnt, o_clr_cyc);
        end
        vectors++;
        if (o_en_cnt !== 4 || o_ovl !== 0 || o_pass_err !== 0) begin
            miscompares++;
            $display("FAIL basic_en got en=%0d ovl=%0d pe=%0d want 4 0 0",
                o_en_cnt, o_ovl, o_pass_err);
        end
    endtask

    task automatic test_gap();
        for (int i = 0; i < 3; i++) begin
            va[i] = 16'hFFFF;
            vb[i] = 16'hFFFF;
        end
        run_vec(3, 1, 1);
        vectors++;
        if (o_res !== 64'h2_FFFA_0003) begin
            miscompares++;
            $display("FAIL gap_res got %0h want 2fffa0003", o_res);
        end
        vectors++;
        if (o_en_cnt !== 3) begin
            miscompares++;
            $display("FAIL gap_en got %0d want 3", o_en_cnt);
        end
        vectors++;
        if (o_vld_cyc !== 9) begin
            miscompares++;
            $display("FAIL gap_vld_cyc got %0d want 9", o_vld_cyc);
        end
    endtask

    task automatic test_len0();
        run_vec(0, 0, 1);
        vectors++;
        if (o_res !== 64'd0) begin
            miscompares++;
            $display("FAIL len0_res got %0h want 0", o_res);
        end
        vectors++;
        if (o_en_cnt !== 0 || o_vld_cyc !== 4) begin
            miscompares++;
            $display("FAIL len0_timing got en=%0d c=%0d want 0 4",
                o_en_cnt, o_vld_cyc);
        end
    endtask

    task automatic test_hold();
        va[0] = 10; vb[0] = 20;
        va[1] = 3;  vb[1] = 3;
        run_vec(2, 0, 0);
        vectors++;
        if (o_res !== 64'd209) begin
            miscompares++;
            $display("FAIL hold_res got %0d want 209", o_res);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = (i % 3 == 0);
            len = 8'd5;
            #1;
            vectors++;
            if (!bus.res_vld || bus.res !== 64'd209 || !busy) begin
                miscompares++;
                $display("FAIL hold_stable got v=%b r=%0d want 1 209",
                    bus.res_vld, bus.res);
            end
        end
        start = 1'b0;
        bus.res_rdy = 1'b1;
        @(negedge clk);
        #1;
        vectors++;
        if (busy || bus.res_vld || bus.res !== 64'd209) begin
            miscompares++;
            $display("FAIL hold_exit got b=%b v=%b r=%0d want 0 0 209",
                busy, bus.res_vld, bus.res);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (busy || mac_clr) begin
            miscompares++;
            $display("FAIL hold_start_ignored got b=%b c=%b want 0 0",
                busy, mac_clr);
        end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 5; i++) begin
            va[i] = 16'(i + 11);
            vb[i] = 16'(i + 7);
        end
        @(negedge clk);
        start = 1'b1;
        len = 8'd5;
        bus.res_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.op_vld = 1'b1;
        bus.op_a = va[0];
        bus.op_b = vb[0];
        @(negedge clk);
        @(negedge clk);
        bus.op_a = va[1];
        bus.op_b = vb[1];
        #1;
        vectors++;
        if (!mac_en || !busy) begin
            miscompares++;
            $display("FAIL rst_mid_run got en=%b b=%b want 1 1",
                mac_en, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({busy, bus.op_rdy, mac_en, bus.res_vld} !== 4'b0 ||
            bus.res !== 64'd0) begin
            miscompares++;
            $display("FAIL rst_mid_out got %b r=%0h want 0000 0",
                {busy, bus.op_rdy, mac_en, bus.res_vld}, bus.res);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.op_vld = 1'b0;
        va[0] = 2; vb[0] = 3;
        va[1] = 4; vb[1] = 5;
        run_vec(2, 0, 1);
        vectors++;
        if (o_res !== 64'd26 || o_vld_cyc !== 6) begin
            miscompares++;
            $display("FAIL rst_mid_res got %0d c=%0d want 26 6",
                o_res, o_vld_cyc);
        end
    endtask

    task automatic test_back_to_back();
        va[0] = 100; vb[0] = 200;
        run_vec(1, 0, 1);
        vectors++;
        if (o_res !== 64'd20000 || o_vld_cyc !== 5) begin
            miscompares++;
            $display("FAIL b2b_first got %0d c=%0d want 20000 5",
                o_res, o_vld_cyc);
        end
        va[0] = 16'hFFFF; vb[0] = 2;
        va[1] = 1;        vb[1] = 1;
        run_vec(2, 0, 1);
        vectors++;
        if (!o_idle0) begin
            miscompares++;
            $display("FAIL b2b_idle got busy=1 want busy=0");
        end
        vectors++;
        if (o_res !== 64'd131071 || o_vld_cyc !== 6) begin
            miscompares++;
            $display("FAIL b2b_second got %0d c=%0d want 131071 6",
                o_res, o_vld_cyc);
        end
    endtask

`ifdef DOT_SEQ_ABORT_EN
    task automatic test_abort();
        va[0] = 6; vb[0] = 6;
        va[1] = 7; vb[1] = 7;
        @(negedge clk);
        start = 1'b1;
        len = 8'd4;
        bus.res_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bus.op_vld = 1'b1;
        bus.op_a = va[0];
        bus.op_b = vb[0];
        @(negedge clk);
        @(negedge clk);
        bus.op_a = va[1];
        bus.op_b = vb[1];
        abort = 1'b1;
        #1;
        vectors++;
        if (mac_en || bus.op_rdy) begin
            miscompares++;
            $display("FAIL abort_cycle got en=%b rdy=%b want 0 0",
                mac_en, bus.op_rdy);
        end
        @(negedge clk);
        abort = 1'b0;
        bus.op_vld = 1'b0;
        #1;
        vectors++;
        if (busy || bus.res_vld || bus.res !== 64'd131071) begin
            miscompares++;
            $display("FAIL abort_idle got b=%b v=%b r=%0d want 0 0 131071",
                busy, bus.res_vld, bus.res);
        end
        va[0] = 9; vb[0] = 9;
        run_vec(1, 0, 1);
        vectors++;
        if (o_res !== 64'd81) begin
            miscompares++;
            $display("FAIL abort_next got %0d want 81", o_res);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_len0();
        test_hold();
        test_rst_mid();
        test_back_to_back();
`ifdef DOT_SEQ_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
            vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dot_prod_seq.md
# dot_prod_seq

Sequencer that drives the gated-clock multiply-accumulate unit to compute a dot product of two 16-bit operand streams. It accepts a start command with a vector length, clears the MAC, and streams operand pairs into it under a valid/ready handshake. It waits out the MAC's two-stage pipeline, then returns the 64-bit accumulator on a valid/ready result port. It sits between the operand source (FIFO or memory reader) and the MAC; the parent instantiates both.

## Interface
- LEN_W, 8, width of vector-length field (max length 2^LEN_W-1)
- clk  in  1  system clock; same clock as the MAC
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a new dot product; sampled only in IDLE
- len  in  LEN_W  number of operand pairs, sampled with start
- op_vld  in  1  operand pair valid
- op_rdy  out  1  sequencer accepts operand pair
- op_a, op_b  in  16  operand pair
- mac_clr  out  1  to MAC clr
- mac_en  out  1  to MAC en
- mac_a, mac_b  out  16  to MAC A, B
- mac_accum  in  64  from MAC accum
- res  out  64  dot-product result
- res_vld  out  1  result valid
- res_rdy  in  1  consumer accepts result
- busy  out  1  high in every state except IDLE
- abort  in  1  only when DOT_SEQ_ABORT_EN is defined

## Operation
- States: IDLE, CLR, RUN, DRAIN1, DRAIN2, DONE.
- IDLE: on start, load cnt<=len and go to CLR. Otherwise stay.
- CLR: mac_clr=1 for exactly one cycle. Go to RUN if cnt!=0, else to DRAIN1.
- RUN: op_rdy=1. On a transfer (op_vld&op_rdy): mac_en=1 and cnt decrements.
  - When the transfer takes cnt from 1 to 0, go to DRAIN1.
  - An op_vld gap holds RUN with mac_en=0.
- DRAIN1, DRAIN2: op_rdy=0, mac_en=0. These states cover the MAC product and accumulate stages.
- DRAIN2: res<=mac_accum at the clock edge; go to DONE.
- DONE: res_vld=1 and res held stable. On res_rdy go to IDLE. res keeps its value after the handshake.
- mac_a/mac_b = op_a/op_b combinationally. mac_en = (state==RUN)&op_vld, which is glitch-free relative to the MAC's low-phase enable latch.
- mac_clr and mac_en are never high in the same cycle.
- len=0 produces res=0.
- start outside IDLE is ignored.
- Products are full 32-bit unsigned. Accumulation wraps modulo 2^64 in the MAC; the sequencer does not detect overflow.
- Reset: state=IDLE, cnt=0, res=0, res_vld=0, op_rdy=0, mac_en=0, mac_clr=0, busy=0.
- Reset mid-operation returns to IDLE. MAC contents are undefined until the next CLR, which always precedes RUN.

## Timing
- MAC contract:
  - en high in cycle t loads prod at edge t.
  - The accumulate happens at edge t+1.
  - accum is valid in cycle t+2.
  - clr in cycle t clears accum at edge t.
- With start in cycle 0 and op_vld continuously high:
  - CLR is cycle 1.
  - Transfers occur in cycles 2..N+1.
  - DRAIN1 is cycle N+2 and DRAIN2 is cycle N+3.
  - res_vld rises in cycle N+4.
- Minimum start-to-res_vld latency is N+4 cycles. Each op_vld gap adds one cycle.
- Back-to-back: with res_rdy high in the first DONE cycle, IDLE follows, and start there begins the next vector. Minimum turnaround is 2 cycles.

## Configuration
- DOT_SEQ_ABORT_EN defined:
  - The abort port exists.
  - abort high in any state other than IDLE forces IDLE at the next edge.
  - mac_en and op_rdy are 0 in the abort cycle.
  - res_vld is not asserted and res keeps its previous value.
  - abort in IDLE has no effect. abort has priority over start and res_rdy.
- DOT_SEQ_ABORT_EN undefined: the abort port and its logic are absent. Behaviour is otherwise identical.

## Structure
- Package dot_seq_pkg holds:
  - the state enum type;
  - OP_W=16, ACC_W=64, PROD_W=32;
  - DRAIN_CYC=2 (MAC pipeline depth).
- No sub-module: the FSM, length counter and result register are a single module. The MAC stays a sibling instance in the parent.

## Test plan
- len=4, pairs (1,2),(3,4),(5,6),(7,8), op_vld always high, res_rdy high -> res=100, res_vld in cycle 8, mac_clr exactly in cycle 1.
- len=3, pairs (0xFFFF,0xFFFF)x3, op_vld toggling every other cycle -> res=0x2_FFFA_0003, 3 mac_en pulses, res_vld delayed by the gap count.
- len=0 -> mac_en never high, res=0, res_vld in cycle 4.
- res_rdy held low 10 cycles in DONE, start pulsed during it -> res stable, start ignored, IDLE only after res_rdy.
- rst asserted in RUN after 2 of 5 pairs, then new start with len=2 (2,3),(4,5) -> outputs reset immediately, second res=26 (stale accum cleared).
- DOT_SEQ_ABORT_EN: abort in RUN after 1 of 4 pairs -> IDLE next cycle, no res_vld, res unchanged. A following len=1 (9,9) gives res=81.
